// File: rtl/kimlik_pkg.sv
// Shared definitions for the kimlik ID validator: FSM state encoding and
// rule-failure codes reported on the optional hata output (KIMLIK_HATA_EN).
package kimlik_pkg;

   typedef enum logic {
      BOS   = 1'b0,
      BITTI = 1'b1
   } durum_e;

   // First failing rule wins, in the order zero, prefix, check bit
   localparam logic [1:0] HATA_YOK    = 2'b00;
   localparam logic [1:0] HATA_SIFIR  = 2'b01;
   localparam logic [1:0] HATA_ONEK   = 2'b10;
   localparam logic [1:0] HATA_PARITE = 2'b11;

endpackage

// File: rtl/kimlik_denetle.sv
// Combinational rule checker: nonzero, MSB matches nationality, odd popcount.
// Reports both a pass flag and the first rule that failed.
module kimlik_denetle
   import kimlik_pkg::*;
#(
   parameter int BIT = 6
) (
   input  logic [BIT-1:0] kimlik_no,
   input  logic           uyruk,
   output logic           gecerli_c,
   output logic [1:0]     hata_c
);

   logic w_sifir;
   logic w_onek_ok;
   logic w_parite_ok;

   assign w_sifir     = (kimlik_no == '0);
   assign w_onek_ok   = (kimlik_no[BIT-1] == uyruk);
   assign w_parite_ok = ^kimlik_no;

   assign gecerli_c = !w_sifir && w_onek_ok && w_parite_ok;

   always_comb begin
      hata_c = HATA_YOK;
      if (w_sifir)
         hata_c = HATA_SIFIR;
      else if (!w_onek_ok)
         hata_c = HATA_ONEK;
      else if (!w_parite_ok)
         hata_c = HATA_PARITE;
   end

endmodule

// File: rtl/kimlik.sv
// Registered ID validator: one edge after basla=1, bitti rises with the verdict.
// Define KIMLIK_HATA_EN to expose the 2-bit failure code output hata.
module kimlik
   import kimlik_pkg::*;
#(
   parameter int BIT = 6
) (
   input  logic           saat,
   input  logic           reset,
   input  logic           basla,
   input  logic [BIT-1:0] kimlik_no,
   input  logic           uyruk,
   output logic           gecerli,
   output logic           bitti
`ifdef KIMLIK_HATA_EN
   ,
   output logic [1:0]     hata
`endif
);

   logic       w_gecerli_c;
   logic [1:0] w_hata_c;
   logic       w_gecerli;

   durum_e     r_durum;
   logic       r_gecerli;

   kimlik_denetle #(
      .BIT (BIT)
   ) u_denetle (
      .kimlik_no (kimlik_no),
      .uyruk     (uyruk),
      .gecerli_c (w_gecerli_c),
      .hata_c    (w_hata_c)
   );

   // Pass flag and failure code are two views of the same rule set
   assign w_gecerli = w_gecerli_c && (w_hata_c == HATA_YOK);

`ifdef KIMLIK_HATA_EN
   logic [1:0] r_hata;

   always_ff @(posedge saat or negedge reset) begin
      if (!reset) begin
         r_durum   <= BOS;
         r_gecerli <= 1'b0;
         r_hata    <= HATA_YOK;
      end else if (basla) begin
         r_durum   <= BITTI;
         r_gecerli <= w_gecerli;
         r_hata    <= w_hata_c;
      end else begin
         r_durum   <= BOS;
      end
   end

   assign hata = r_hata;
`else
   always_ff @(posedge saat or negedge reset) begin
      if (!reset) begin
         r_durum   <= BOS;
         r_gecerli <= 1'b0;
      end else if (basla) begin
         r_durum   <= BITTI;
         r_gecerli <= w_gecerli;
      end else begin
         r_durum   <= BOS;
      end
   end
`endif

   // Verdict holds across idle cycles; done is simply the state
   assign gecerli = r_gecerli;
   assign bitti   = (r_durum == BITTI);

endmodule

// File: tb/tb_kimlik.sv
// Directed bench for kimlik (BIT=6); also checks hata when KIMLIK_HATA_EN is set.
module tb_kimlik;

   logic       saat;
   logic       reset;
   logic       basla;
   logic [5:0] kimlik_no;
   logic       uyruk;
   logic       gecerli;
   logic       bitti;
`ifdef KIMLIK_HATA_EN
   logic [1:0] hata;
`endif

   int checks   = 0;
   int failures = 0;

   kimlik #(.BIT(6)) dut (
      .saat      (saat),
      .reset     (reset),
      .basla     (basla),
      .kimlik_no (kimlik_no),
      .uyruk     (uyruk),
      .gecerli   (gecerli),
      .bitti     (bitti)
`ifdef KIMLIK_HATA_EN
      ,
      .hata      (hata)
`endif
   );

   initial saat = 1'b0;
   always #5 saat = ~saat;

   task automatic drive(input logic b, input logic [5:0] k, input logic u);
      basla     = b;
      kimlik_no = k;
      uyruk     = u;
   endtask

   task automatic tick();
      @(posedge saat);
      #1;
   endtask

   task automatic pulse_reset();
      @(negedge saat);
      reset = 1'b0;
      #2;
      reset = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drive(1'b1, 6'b000111, 1'b0);
      tick();
      tick();
      checks++;
      if (bitti !== 1'b0 || gecerli !== 1'b0) begin
         failures++;
         $display("FAIL reset_state bitti=%b gecerli=%b expected 0 0", bitti, gecerli);
      end
`ifdef KIMLIK_HATA_EN
      checks++;
      if (hata !== 2'b00) begin
         failures++;
         $display("FAIL reset_hata got=%b expected=00", hata);
      end
`endif
      @(negedge saat);
      reset = 1'b1;
   endtask

   task automatic test_citizen_valid();
      drive(1'b1, 6'b000111, 1'b0);
      tick();
      checks++;
      if (bitti !== 1'b1 || gecerli !== 1'b1) begin
         failures++;
         $display("FAIL citizen_valid bitti=%b gecerli=%b expected 1 1", bitti, gecerli);
      end
      pulse_reset();
      drive(1'b0, 6'b000111, 1'b0);
      tick();
      checks++;
      if (bitti !== 1'b0 || gecerli !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_reset bitti=%b gecerli=%b expected 0 0", bitti, gecerli);
      end
   endtask

   task automatic test_foreign_hold();
      @(negedge saat);
      drive(1'b1, 6'b110111, 1'b1);
      tick();
      checks++;
      if (bitti !== 1'b1 || gecerli !== 1'b1) begin
         failures++;
         $display("FAIL foreign_valid bitti=%b gecerli=%b expected 1 1", bitti, gecerli);
      end
      @(negedge saat);
      drive(1'b0, 6'b110111, 1'b1);
      tick();
      checks++;
      if (bitti !== 1'b0 || gecerli !== 1'b1) begin
         failures++;
         $display("FAIL hold_after_done bitti=%b gecerli=%b expected 0 1", bitti, gecerli);
      end
      // Inputs that would fail must not disturb the held verdict while idle
      @(negedge saat);
      drive(1'b0, 6'b000000, 1'b0);
      tick();
      tick();
      checks++;
      if (bitti !== 1'b0 || gecerli !== 1'b1) begin
         failures++;
         $display("FAIL idle_input_change bitti=%b gecerli=%b expected 0 1", bitti, gecerli);
      end
   endtask

   task automatic test_rules();
      pulse_reset();
      @(negedge saat);
      drive(1'b1, 6'b000000, 1'b1);
      tick();
      checks++;
      if (bitti !== 1'b1 || gecerli !== 1'b0) begin
         failures++;
         $display("FAIL zero_number bitti=%b gecerli=%b expected 1 0", bitti, gecerli);
      end
`ifdef KIMLIK_HATA_EN
      checks++;
      if (hata !== 2'b01) begin
         failures++;
         $display("FAIL zero_hata got=%b expected=01", hata);
      end
`endif
      @(negedge saat);
      drive(1'b1, 6'b000111, 1'b1);
      tick();
      checks++;
      if (bitti !== 1'b1 || gecerli !== 1'b0) begin
         failures++;
         $display("FAIL prefix_mismatch bitti=%b gecerli=%b expected 1 0", bitti, gecerli);
      end
`ifdef KIMLIK_HATA_EN
      checks++;
      if (hata !== 2'b10) begin
         failures++;
         $display("FAIL prefix_hata got=%b expected=10", hata);
      end
`endif
      @(negedge saat);
      drive(1'b1, 6'b000011, 1'b0);
      tick();
      checks++;
      if (bitti !== 1'b1 || gecerli !== 1'b0) begin
         failures++;
         $display("FAIL parity_even bitti=%b gecerli=%b expected 1 0", bitti, gecerli);
      end
`ifdef KIMLIK_HATA_EN
      checks++;
      if (hata !== 2'b11) begin
         failures++;
         $display("FAIL parity_hata got=%b expected=11", hata);
      end
`endif
   endtask

   task automatic test_back_to_back();
      logic [5:0] vec_k [6];
      logic       vec_u [6];
      logic       vec_g [6];
      vec_k[0] = 6'b000111; vec_u[0] = 1'b0; vec_g[0] = 1'b1;
      vec_k[1] = 6'b101010; vec_u[1] = 1'b1; vec_g[1] = 1'b1;
      vec_k[2] = 6'b100001; vec_u[2] = 1'b1; vec_g[2] = 1'b0;
      vec_k[3] = 6'b100000; vec_u[3] = 1'b1; vec_g[3] = 1'b1;
      vec_k[4] = 6'b111111; vec_u[4] = 1'b1; vec_g[4] = 1'b0;
      vec_k[5] = 6'b000001; vec_u[5] = 1'b0; vec_g[5] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge saat);
         drive(1'b1, vec_k[i], vec_u[i]);
         tick();
         checks++;
         if (bitti !== 1'b1 || gecerli !== vec_g[i]) begin
            failures++;
            $display("FAIL back_to_back[%0d] bitti=%b gecerli=%b expected 1 %b",
                     i, bitti, gecerli, vec_g[i]);
         end
      end
   endtask

   task automatic test_reset_mid_check();
      @(negedge saat);
      drive(1'b1, 6'b110111, 1'b1);
      tick();
      checks++;
      if (bitti !== 1'b1 || gecerli !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset_valid bitti=%b gecerli=%b expected 1 1", bitti, gecerli);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (bitti !== 1'b0 || gecerli !== 1'b0) begin
         failures++;
         $display("FAIL async_reset bitti=%b gecerli=%b expected 0 0", bitti, gecerli);
      end
      @(negedge saat);
      reset = 1'b1;
      tick();
      checks++;
      if (bitti !== 1'b1 || gecerli !== 1'b1) begin
         failures++;
         $display("FAIL fresh_after_reset bitti=%b gecerli=%b expected 1 1", bitti, gecerli);
      end
   endtask

   initial begin
      reset = 1'b0;
      drive(1'b0, 6'b000000, 1'b0);
      test_reset();
      test_citizen_valid();
      test_foreign_hold();
      test_rules();
      test_back_to_back();
      test_reset_mid_check();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
